// File: rtl/temp_sample_filter.sv
// Sliding-window average of raw temperature samples with spike rejection and stall detection.
// Latency: a sample accepted at edge k updates current_temp/spike_count at edge k; fault asserts one edge after idle saturates.
// Backpressure: none; a sample may arrive every cycle and is always consumed (accepted or rejected).
//
// Ports:
//   clk, reset (async, active-low)
//   sample_valid/sample_data : raw sensor strobe and reading
//   current_temp/temp_valid  : filtered temperature, valid only while tracking a full window
//   sensor_fault             : sensor stalled for TIMEOUT cycles
//   spike_count              : saturating count of rejected samples
module temp_sample_filter #(
  parameter int WIDTH       = 8,
  parameter int AVG_LOG2    = 2,
  parameter int SPIKE_LIMIT = 16,
  parameter int SPIKE_RUN   = 3,
  parameter int TIMEOUT     = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample_data,
  output logic [WIDTH-1:0] current_temp,
  output logic             temp_valid,
  output logic             sensor_fault,
  output logic [7:0]       spike_count
);

  localparam int N      = 1 << AVG_LOG2;
  localparam int SUM_W  = WIDTH + AVG_LOG2;
  localparam int FILL_W = AVG_LOG2 + 1;
  localparam int RUN_W  = $clog2(SPIKE_RUN + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {FILL, TRACK, FAULT} state_t;

  state_t              state;
  logic [WIDTH-1:0]    buf_q [N];
  logic [AVG_LOG2-1:0] wr_ptr;
  logic [SUM_W-1:0]    sum_q;
  logic [FILL_W-1:0]   fill_cnt;
  logic [RUN_W-1:0]    run_cnt;
  logic [IDLE_W-1:0]   idle_cnt;

  logic [SUM_W-1:0]    sum_acc;
  logic [WIDTH:0]      diff;
  logic                out_of_range;
  logic [RUN_W-1:0]    run_inc;
  logic                run_done;
  logic                idle_hit;

  always_comb begin
    // Running sum stays exact: the slot being overwritten is the oldest sample.
    sum_acc = sum_q - SUM_W'(buf_q[wr_ptr]) + SUM_W'(sample_data);
    // One extra bit so the absolute difference never wraps.
    if ({1'b0, sample_data} >= {1'b0, current_temp})
      diff = {1'b0, sample_data} - {1'b0, current_temp};
    else
      diff = {1'b0, current_temp} - {1'b0, sample_data};
    out_of_range = diff > (WIDTH+1)'(SPIKE_LIMIT);
    run_inc      = run_cnt + RUN_W'(1);
    run_done     = run_inc == RUN_W'(SPIKE_RUN);
    idle_hit     = idle_cnt == IDLE_W'(TIMEOUT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= FILL;
      for (int i = 0; i < N; i++) buf_q[i] <= '0;
      wr_ptr       <= '0;
      sum_q        <= '0;
      fill_cnt     <= '0;
      run_cnt      <= '0;
      idle_cnt     <= '0;
      current_temp <= '0;
      temp_valid   <= 1'b0;
      sensor_fault <= 1'b0;
      spike_count  <= '0;
    end else begin
      // Any strobe, even a rejected spike, proves the sensor is alive.
      if (sample_valid)
        idle_cnt <= '0;
      else if (!idle_hit)
        idle_cnt <= idle_cnt + IDLE_W'(1);

      case (state)
        FILL: begin
          if (sample_valid) begin
            buf_q[wr_ptr] <= sample_data;
            sum_q         <= sum_acc;
            wr_ptr        <= wr_ptr + 1'b1;
            fill_cnt      <= fill_cnt + 1'b1;
            if (fill_cnt == FILL_W'(N - 1)) begin
              state        <= TRACK;
              temp_valid   <= 1'b1;
              current_temp <= sum_acc[SUM_W-1:AVG_LOG2];
            end
          end else if (idle_hit) begin
            state        <= FAULT;
            sensor_fault <= 1'b1;
          end
        end

        TRACK: begin
          if (sample_valid) begin
            // A sustained run of out-of-range samples is a real step, not a spike.
            if (!out_of_range || run_done) begin
              buf_q[wr_ptr] <= sample_data;
              sum_q         <= sum_acc;
              wr_ptr        <= wr_ptr + 1'b1;
              current_temp  <= sum_acc[SUM_W-1:AVG_LOG2];
              run_cnt       <= '0;
            end else begin
              run_cnt <= run_inc;
              if (spike_count != 8'hFF)
                spike_count <= spike_count + 8'd1;
            end
          end else if (idle_hit) begin
            state        <= FAULT;
            temp_valid   <= 1'b0;
            sensor_fault <= 1'b1;
          end
        end

        FAULT: begin
          // Restart the window from scratch; the waking sample is the first fill entry.
          if (sample_valid) begin
            for (int i = 0; i < N; i++) buf_q[i] <= '0;
            buf_q[0]     <= sample_data;
            sum_q        <= SUM_W'(sample_data);
            wr_ptr       <= AVG_LOG2'(1);
            fill_cnt     <= FILL_W'(1);
            run_cnt      <= '0;
            state        <= FILL;
            sensor_fault <= 1'b0;
          end
        end

        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: doc/temp_sample_filter.md
# temp_sample_filter

Upstream conditioning stage for the auto temperature controller. It accepts raw 8-bit sensor samples with a valid strobe and averages them over a sliding window. It rejects isolated spikes and detects a stalled sensor. Its `current_temp`/`temp_valid` outputs drive the controller's `current_temp` input; `sensor_fault` lets the controller force heater and cooler off.

## Interface
Parameters:
- `WIDTH`, 8, sample and output temperature width
- `AVG_LOG2`, 2, log2 of averaging window depth N (N = 4)
- `SPIKE_LIMIT`, 16, maximum accepted |sample − current_temp| while tracking
- `SPIKE_RUN`, 3, consecutive out-of-range samples that are accepted as a real step
- `TIMEOUT`, 1000, cycles without `sample_valid` before fault

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `sample_valid`  in  1  one-cycle strobe; `sample_data` is valid this cycle
- `sample_data`  in  WIDTH  raw sensor reading, unsigned
- `current_temp`  out  WIDTH  filtered temperature, registered
- `temp_valid`  out  1  `current_temp` is a full-window average
- `sensor_fault`  out  1  sensor stalled; registered
- `spike_count`  out  8  rejected-sample count; saturates at 255

## Operation
- N-entry circular buffer, write pointer, running sum of WIDTH+AVG_LOG2 bits, fill counter 0..N.
- Accepting a sample: overwrite the oldest entry; sum = sum − oldest + sample; advance pointer (wraps N−1→0).
- `current_temp` = sum >> AVG_LOG2, truncated, updated only when the buffer is full.
- FSM states:
  - FILL (reset state): every valid sample is accepted; no spike check. After the Nth accepted sample → TRACK.
  - TRACK: diff = |sample − current_temp| computed in WIDTH+1 bits.
    - diff ≤ SPIKE_LIMIT: accept; clear the run counter.
    - diff > SPIKE_LIMIT: increment the run counter. If it reaches SPIKE_RUN: accept and clear it. Otherwise reject and increment `spike_count` (saturating).
    - Direction is ignored when counting the run.
  - FAULT: entered from FILL or TRACK when the idle counter reaches TIMEOUT.
    - The next valid sample clears the buffer, sum, fill count and run counter.
    - That sample is accepted as the first fill sample → FILL.
- Idle counter: cleared on any `sample_valid` (accepted or rejected); otherwise increments and saturates at TIMEOUT.
- `temp_valid` = 1 only in TRACK.
- `sensor_fault` = 1 only in FAULT.
- `current_temp` holds its last value through FILL-after-FAULT and FAULT.
- `spike_count` is cleared only by reset.

## Timing
- Reset (async assert, sync release): `current_temp`=0, `temp_valid`=0, `sensor_fault`=0, `spike_count`=0; buffer, sum, counters = 0; state FILL.
- Latency: a sample accepted at edge k updates `current_temp` and `spike_count` at edge k (visible after k).
- `temp_valid` rises at the same edge as the Nth fill sample.
- Idle counter reaching TIMEOUT at edge k: state FAULT at edge k+1; `sensor_fault`=1 and `temp_valid`=0 from edge k+1.
- `sample_valid` on the cycle the idle counter would reach TIMEOUT: the sample wins, the counter clears, no fault.
- Recovery: `sensor_fault` drops at the edge that accepts the first post-fault sample; `temp_valid` returns N accepted samples later.
- Back-to-back `sample_valid` every cycle is supported; no backpressure.
- Reset asserted mid-fill or mid-tracking discards all state immediately.

## Test plan
Bench parameters: WIDTH=8, AVG_LOG2=2, SPIKE_LIMIT=16, SPIKE_RUN=3, TIMEOUT=16.
- Reset release, then samples 70,70,72,72 → `temp_valid` rises with the 4th sample; `current_temp`=71 (284>>2).
- From that state, a single sample of 200 → rejected; `current_temp` stays 71; `spike_count`=1; the next sample of 71 is accepted and clears the run.
- From buffer {70,70,72,72}, send 100,100,100:
  - The first two are rejected (`spike_count` +2).
  - The third is accepted, replacing the oldest 70 → `current_temp`=78 (314>>2).
- Boundary at `current_temp`=71: sample 87 (diff 16) is accepted; a fresh sample 88 after re-settling (diff 17) is rejected.
- Timeout:
  - No `sample_valid` for 16 cycles → `sensor_fault`=1 and `temp_valid`=0 one cycle later; `current_temp` held.
  - Then samples 65×4 → fault clears on the first sample; `temp_valid`=1 and `current_temp`=65 after the 4th.
  - A sample on exactly the 16th idle cycle → no fault.
- `reset` low after 2 fill samples → all outputs 0 immediately; 4 new samples of 40 → `current_temp`=40, `temp_valid`=1.
